// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI memory responder: opcodes, FSM states, field sizes.
package qspi_pkg;

    localparam logic [7:0] CMD_READ_DEFAULT  = 8'h0B;
    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h02;

    localparam int CNT_W        = 4;
    localparam int ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        READ,
        WRITE,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchroniser for the QSPI pins, with edge pulses for qspi clock and chip select.
module qspi_edge_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       qspi_clk_in,
    input  logic       qspi_cs_n,
    input  logic [3:0] qspi_data_in,
    output logic [3:0] data,
    output logic       cs_n,
    output logic       clk_rise,
    output logic       clk_fall,
    output logic       cs_fall
);

    logic [5:0] meta;
    logic [5:0] sync;
    logic       clk_prev;
    logic       cs_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: cs_n resets to "selected" so a select already low at reset release
            // produces no fall; the responder waits for a fresh select.
            meta     <= '0;
            sync     <= '0;
            clk_prev <= 1'b0;
            cs_prev  <= 1'b0;
        end else begin
            meta     <= {qspi_cs_n, qspi_clk_in, qspi_data_in};
            sync     <= meta;
            clk_prev <= sync[4];
            cs_prev  <= sync[5];
        end
    end

    assign data     = sync[3:0];
    assign cs_n     = sync[5];
    assign clk_rise = sync[4] & ~clk_prev;
    assign clk_fall = ~sync[4] & clk_prev;
    assign cs_fall  = ~sync[5] & cs_prev;

endmodule

// File: rtl/qspi_mem_responder.sv
// QSPI target that decodes quad read/write commands and drives a byte-wide memory port.
module qspi_mem_responder
    import qspi_pkg::*;
#(
    parameter int         ADDR_BITS     = 16,
    parameter int         DUMMY_NIBBLES = 4,
    parameter logic [7:0] CMD_READ      = CMD_READ_DEFAULT,
    parameter logic [7:0] CMD_WRITE     = CMD_WRITE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 qspi_clk_in,
    input  logic                 qspi_cs_n,
    input  logic [3:0]           qspi_data_in,
    output logic [3:0]           qspi_data_out,
    output logic                 qspi_data_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_re,
    input  logic [7:0]           mem_rdata,
    output logic                 mem_we,
    output logic [7:0]           mem_wdata,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_NIBBLES - 1);
    localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_NIBBLES - 1);

    logic [3:0] data_s;
    logic       cs_n_s;
    logic       clk_rise;
    logic       clk_fall;
    logic       cs_fall;

    qspi_edge_sync u_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .qspi_clk_in  (qspi_clk_in),
        .qspi_cs_n    (qspi_cs_n),
        .qspi_data_in (qspi_data_in),
        .data         (data_s),
        .cs_n         (cs_n_s),
        .clk_rise     (clk_rise),
        .clk_fall     (clk_fall),
        .cs_fall      (cs_fall)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cmd_hi;
    logic [3:0]       wr_hi;
    logic             is_read;
    logic             phase;
    logic             re_d;
    logic [7:0]       rdata_q;
    logic [7:0]       cur_byte;

    // Read data is live the cycle after mem_re; afterwards it is held in rdata_q.
    assign cur_byte = re_d ? mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            cmd_hi        <= '0;
            wr_hi         <= '0;
            is_read       <= 1'b0;
            phase         <= 1'b0;
            re_d          <= 1'b0;
            rdata_q       <= '0;
            qspi_data_out <= '0;
            qspi_data_oe  <= 1'b0;
            mem_addr      <= '0;
            mem_re        <= 1'b0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            re_d   <= mem_re;
            if (re_d) rdata_q <= mem_rdata;
            if (mem_we) mem_addr <= mem_addr + 1'b1;

            if (state != IDLE && cs_n_s) begin
                state         <= IDLE;
                busy          <= 1'b0;
                qspi_data_oe  <= 1'b0;
                qspi_data_out <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= CMD;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    CMD: begin
                        if (clk_rise) begin
                            if (cnt == '0) begin
                                cmd_hi <= data_s;
                                cnt    <= cnt + 1'b1;
                            end else begin
                                cnt <= '0;
                                if ({cmd_hi, data_s} == CMD_READ) begin
                                    is_read <= 1'b1;
                                    state   <= ADDR;
                                end else if ({cmd_hi, data_s} == CMD_WRITE) begin
                                    is_read <= 1'b0;
                                    state   <= ADDR;
                                end else begin
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (clk_rise) begin
                            // Shifting through the register keeps only the low ADDR_BITS.
                            mem_addr <= {mem_addr[ADDR_BITS-5:0], data_s};
                            if (cnt == LAST_ADDR) begin
                                cnt   <= '0;
                                phase <= 1'b0;
                                if (!is_read) begin
                                    state <= WRITE;
                                end else if (DUMMY_NIBBLES == 0) begin
                                    state  <= READ;
                                    mem_re <= 1'b1;
                                end else begin
                                    state <= DUMMY;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    DUMMY: begin
                        if (clk_rise) begin
                            if (cnt == '0) mem_re <= 1'b1;
                            if (cnt == LAST_DUMMY) begin
                                cnt   <= '0;
                                state <= READ;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (clk_fall) begin
                            qspi_data_oe <= 1'b1;
                            if (!phase) begin
                                qspi_data_out <= cur_byte[7:4];
                                phase         <= 1'b1;
                            end else begin
                                qspi_data_out <= cur_byte[3:0];
                                phase         <= 1'b0;
                                mem_addr      <= mem_addr + 1'b1;
                                mem_re        <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        if (clk_rise) begin
                            if (!phase) begin
                                wr_hi <= data_s;
                                phase <= 1'b1;
                            end else begin
                                mem_wdata <= {wr_hi, data_s};
                                mem_we    <= 1'b1;
                                phase     <= 1'b0;
                            end
                        end
                    end
                    IGNORE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench for qspi_mem_responder: a QSPI controller driven from one initial block.
module tb_qspi_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        qspi_clk_in = 1'b0;
    logic        qspi_cs_n = 1'b0;
    logic [3:0]  qspi_data_in = '0;
    logic [3:0]  qspi_data_out;
    logic        qspi_data_oe;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [7:0]  mem_rdata = '0;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        busy;

    qspi_mem_responder #(
        .ADDR_BITS     (16),
        .DUMMY_NIBBLES (4),
        .CMD_READ      (8'h0B),
        .CMD_WRITE     (8'h02)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .qspi_clk_in   (qspi_clk_in),
        .qspi_cs_n     (qspi_cs_n),
        .qspi_data_in  (qspi_data_in),
        .qspi_data_out (qspi_data_out),
        .qspi_data_oe  (qspi_data_oe),
        .mem_addr      (mem_addr),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Memory model: read data valid exactly one clock after mem_re; strobes are logged.
    logic [7:0]  mem [0:65535];
    logic [23:0] we_log[$];
    int          re_cnt = 0;
    int          both_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_re) begin
                mem_rdata <= mem[mem_addr];
                re_cnt    <= re_cnt + 1;
            end
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                we_log.push_back({mem_addr, mem_wdata});
            end
            if (mem_re && mem_we) both_cnt <= both_cnt + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [3:0] obs_nib;
    logic       obs_oe;
    logic       oe_any;
    int         we_base;
    int         re_base;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One QSPI clock: data set after the fall, output sampled just before the rise.
    task automatic nib(input logic [3:0] n);
        qspi_data_in = n;
        #40;
        obs_nib = qspi_data_out;
        obs_oe  = qspi_data_oe;
        oe_any  = oe_any | qspi_data_oe;
        qspi_clk_in = 1'b1;
        #40;
        qspi_clk_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        nib(b[7:4]);
        nib(b[3:0]);
    endtask

    task automatic start(input logic [7:0] op, input logic [23:0] a);
        qspi_cs_n = 1'b0;
        #40;
        send_byte(op);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    task automatic stop();
        qspi_cs_n = 1'b1;
        #80;
    endtask

    task automatic dummies();
        for (int i = 0; i < 4; i++) nib(4'h0);
    endtask

    initial begin
        oe_any = 1'b0;
        #30;
        check("rst_oe",    32'(qspi_data_oe), 32'h0);
        check("rst_dout",  32'(qspi_data_out), 32'h0);
        check("rst_re",    32'(mem_re), 32'h0);
        check("rst_we",    32'(mem_we), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_addr",  32'(mem_addr), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);

        // Select already low at reset release: the whole burst must be ignored.
        rst_n = 1'b1;
        #40;
        we_base = we_log.size();
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) nib(4'h0);
        send_byte(8'h55);
        check("cslow_busy", 32'(busy), 32'h0);
        check("cslow_we",   32'(we_log.size() - we_base), 32'd0);
        stop();

        // Write A5 3C at 0x0010.
        we_base = we_log.size();
        re_base = re_cnt;
        start(8'h02, 24'h000010);
        send_byte(8'hA5);
        check("wr_busy", 32'(busy), 32'h1);
        send_byte(8'h3C);
        stop();
        check("wr_count",  32'(we_log.size() - we_base), 32'd2);
        check("wr_0",      32'(we_log[we_base]), 32'h0010A5);
        check("wr_1",      32'(we_log[we_base+1]), 32'h00113C);
        check("wr_no_re",  32'(re_cnt - re_base), 32'd0);
        check("wr_idle",   32'(busy), 32'h0);

        // Read back from 0x0010.
        re_base = re_cnt;
        we_base = we_log.size();
        start(8'h0B, 24'h000010);
        dummies();
        check("rd_oe_pre", 32'(obs_oe), 32'h0);
        nib(4'h0);
        check("rd_oe",  32'(obs_oe), 32'h1);
        check("rd_n0",  32'(obs_nib), 32'hA);
        nib(4'h0);
        check("rd_n1",  32'(obs_nib), 32'h5);
        nib(4'h0);
        check("rd_n2",  32'(obs_nib), 32'h3);
        nib(4'h0);
        check("rd_n3",  32'(obs_nib), 32'hC);
        stop();
        check("rd_re_count", 32'(re_cnt - re_base), 32'd3);
        check("rd_no_we",    32'(we_log.size() - we_base), 32'd0);
        check("rd_oe_off",   32'(qspi_data_oe), 32'h0);
        check("rd_idle",     32'(busy), 32'h0);

        // Address wrap at the top of the 16-bit space.
        we_base = we_log.size();
        start(8'h02, 24'h00FFFF);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        stop();
        check("wrap_count", 32'(we_log.size() - we_base), 32'd3);
        check("wrap_0",     32'(we_log[we_base]), 32'hFFFF11);
        check("wrap_1",     32'(we_log[we_base+1]), 32'h000022);
        check("wrap_2",     32'(we_log[we_base+2]), 32'h000133);

        // Half byte dropped on deselect, then a read of the completed byte.
        we_base = we_log.size();
        start(8'h02, 24'h000020);
        send_byte(8'h7E);
        nib(4'h9);
        stop();
        check("part_count", 32'(we_log.size() - we_base), 32'd1);
        check("part_0",     32'(we_log[we_base]), 32'h00207E);
        start(8'h0B, 24'h000020);
        dummies();
        nib(4'h0);
        check("part_rd_hi", 32'(obs_nib), 32'h7);
        nib(4'h0);
        check("part_rd_lo", 32'(obs_nib), 32'hE);
        stop();

        // Unknown opcode is ignored until deselect.
        we_base = we_log.size();
        re_base = re_cnt;
        oe_any  = 1'b0;
        qspi_cs_n = 1'b0;
        #40;
        send_byte(8'h9F);
        for (int i = 0; i < 16; i++) nib(4'hF);
        check("ign_busy", 32'(busy), 32'h1);
        stop();
        check("ign_oe",   32'(oe_any), 32'h0);
        check("ign_we",   32'(we_log.size() - we_base), 32'd0);
        check("ign_re",   32'(re_cnt - re_base), 32'd0);
        check("ign_idle", 32'(busy), 32'h0);

        // Reset in the middle of a read, then a fresh read.
        start(8'h0B, 24'h000010);
        dummies();
        nib(4'h0);
        nib(4'h0);
        check("mid_n1", 32'(obs_nib), 32'h5);
        rst_n = 1'b0;
        #1;
        check("mrst_oe",   32'(qspi_data_oe), 32'h0);
        check("mrst_dout", 32'(qspi_data_out), 32'h0);
        check("mrst_re",   32'(mem_re), 32'h0);
        check("mrst_we",   32'(mem_we), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        check("mrst_addr", 32'(mem_addr), 32'h0);
        #39;
        qspi_cs_n = 1'b1;
        #40;
        rst_n = 1'b1;
        #80;
        start(8'h0B, 24'h000011);
        dummies();
        nib(4'h0);
        check("post_hi", 32'(obs_nib), 32'h3);
        nib(4'h0);
        check("post_lo", 32'(obs_nib), 32'hC);
        stop();

        check("no_dual_strobe", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
